// File: rtl/fwd_hazard_ctrl.sv
// Forwarding / load-use hazard controller for a 5-stage pipeline.
// Tracks EX/MEM/WB destination records and drives the EX operand mux selects, stall and flush.
module fwd_hazard_ctrl #(
    parameter int REG_AW     = 5,
    parameter bit LOAD_STALL = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              branch_taken,
    output logic [1:0]        sel_a,
    output logic [1:0]        sel_b,
    output logic              stall,
    output logic              flush
);

    typedef struct packed {
        logic              valid;
        logic              regwrite;
        logic              memread;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic              uses_rs;
        logic              uses_rt;
    } rec_t;

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;

    rec_t ex_r, mem_r, wb_r, id_rec;
    logic load_use;

    always_comb begin
        id_rec          = '0;
        id_rec.valid    = id_valid;
        id_rec.regwrite = id_reg_write;
        id_rec.memread  = id_mem_read;
        id_rec.rd       = id_rd;
        id_rec.rs       = id_rs;
        id_rec.rt       = id_rt;
        id_rec.uses_rs  = id_uses_rs;
        id_rec.uses_rt  = id_uses_rt;
    end

    // A load sitting in MEM has no ALU result to forward, so it is skipped
    // and the WB record gets a chance instead.
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src, input logic use_src,
                                           input rec_t ex, input rec_t mem, input rec_t wb);
        logic [1:0] s;
        s = SEL_RF;
        if (ex.valid && use_src) begin
            if (mem.valid && mem.regwrite && !mem.memread && mem.rd != '0 && mem.rd == src)
                s = SEL_MEM;
            else if (wb.valid && wb.regwrite && wb.rd != '0 && wb.rd == src)
                s = SEL_WB;
        end
        return s;
    endfunction

    assign sel_a = fwd_sel(ex_r.rs, ex_r.uses_rs, ex_r, mem_r, wb_r);
    assign sel_b = fwd_sel(ex_r.rt, ex_r.uses_rt, ex_r, mem_r, wb_r);

    assign load_use = id_valid && ex_r.valid && ex_r.memread && ex_r.rd != '0 &&
                      ((id_uses_rs && id_rs == ex_r.rd) || (id_uses_rt && id_rt == ex_r.rd));

    // Flush wins over stall; both are forced low while reset is held.
    assign stall = rst_n && LOAD_STALL && load_use && !branch_taken;
    assign flush = rst_n && branch_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_r  <= '0;
            mem_r <= '0;
            wb_r  <= '0;
        end else begin
            wb_r  <= mem_r;
            mem_r <= ex_r;
            ex_r  <= (stall || flush || !id_valid) ? rec_t'('0) : id_rec;
        end
    end

    // Fields carried along for completeness but not consulted downstream.
    logic unused_fields;
    assign unused_fields = ^{mem_r.rs, mem_r.rt, mem_r.uses_rs, mem_r.uses_rt,
                             wb_r.memread, wb_r.rs, wb_r.rt, wb_r.uses_rs, wb_r.uses_rt};

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: forwarding selects, load-use stall, r0, flush, async reset.
module tb_fwd_hazard_ctrl;

    logic       clk, rst_n;
    logic       id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read, branch_taken;
    logic [4:0] id_rs, id_rt, id_rd;
    logic [1:0] sel_a, sel_b;
    logic       stall, flush;

    int n_cmp = 0;
    int n_err = 0;

    fwd_hazard_ctrl #(.REG_AW(5), .LOAD_STALL(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .branch_taken(branch_taken),
        .sel_a(sel_a), .sel_b(sel_b), .stall(stall), .flush(flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // valid, rs, rt, uses_rs, uses_rt, rd, regwrite, memread
    task automatic id_set(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt, input logic [4:0] rd,
                          input logic rw, input logic mr);
        id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
        id_rd = rd; id_reg_write = rw; id_mem_read = mr;
    endtask

    task automatic nop();
        id_set(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic adv();
        @(posedge clk); #1;
    endtask

    task automatic drain();
        nop(); branch_taken = 1'b0;
        repeat (3) adv();
    endtask

    initial begin
        rst_n = 1'b0; branch_taken = 1'b0; nop();
        #1;
        // 1: reset with random inputs
        for (int i = 0; i < 3; i++) begin
            id_set(1'b1, 5'($urandom), 5'($urandom), 1'b1, 1'b1, 5'($urandom), 1'b1, 1'($urandom));
            branch_taken = 1'b1;
            #1;
            chk("rst_sel_a", {6'd0, sel_a}, 8'd0);
            chk("rst_sel_b", {6'd0, sel_b}, 8'd0);
            chk("rst_stall", {7'd0, stall}, 8'd0);
            chk("rst_flush", {7'd0, flush}, 8'd0);
            adv();
        end
        rst_n = 1'b1;
        drain();

        // 2: EX->EX forwarding from MEM
        id_set(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0); adv();   // add r3,r1,r2
        id_set(1, 5'd3, 5'd1, 1, 1, 5'd4, 1, 0); adv();   // sub r4,r3,r1
        nop(); #1;
        chk("exfwd_sel_a", {6'd0, sel_a}, 8'h01);
        chk("exfwd_sel_b", {6'd0, sel_b}, 8'h00);
        chk("exfwd_stall", {7'd0, stall}, 8'd0);
        drain();

        // 3a: MEM beats WB on both operands
        id_set(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0); adv();
        id_set(1, 5'd1, 5'd1, 1, 1, 5'd3, 1, 0); adv();
        id_set(1, 5'd3, 5'd3, 1, 1, 5'd5, 1, 0); adv();   // or r5,r3,r3
        nop(); #1;
        chk("prio_sel_a", {6'd0, sel_a}, 8'h01);
        chk("prio_sel_b", {6'd0, sel_b}, 8'h01);
        drain();

        // 3b: one nop between -> WB path
        id_set(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0); adv();
        nop(); adv();
        id_set(1, 5'd3, 5'd3, 1, 1, 5'd5, 1, 0); adv();
        nop(); #1;
        chk("wbfwd_sel_a", {6'd0, sel_a}, 8'h02);
        chk("wbfwd_sel_b", {6'd0, sel_b}, 8'h02);
        drain();

        // 3c: mixed, rs from WB and rt from MEM
        id_set(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0); adv();
        id_set(1, 5'd1, 5'd2, 1, 1, 5'd4, 1, 0); adv();
        id_set(1, 5'd3, 5'd4, 1, 1, 5'd5, 1, 0); adv();
        nop(); #1;
        chk("mix_sel_a", {6'd0, sel_a}, 8'h02);
        chk("mix_sel_b", {6'd0, sel_b}, 8'h01);
        drain();

        // 3d: no regwrite in producer -> no forward
        id_set(1, 5'd1, 5'd2, 1, 1, 5'd3, 0, 0); adv();
        id_set(1, 5'd3, 5'd3, 1, 1, 5'd5, 1, 0); adv();
        nop(); #1;
        chk("norw_sel_a", {6'd0, sel_a}, 8'h00);
        drain();

        // 4: load-use, one bubble then WB forward
        id_set(1, 5'd1, 5'd0, 1, 0, 5'd2, 1, 1); adv();   // lw r2
        id_set(1, 5'd2, 5'd7, 1, 1, 5'd6, 1, 0); #1;      // add r6,r2,r7
        chk("lu_stall_c0", {7'd0, stall}, 8'd1);
        adv();
        chk("lu_stall_c1", {7'd0, stall}, 8'd0);
        chk("lu_bubble_sel_a", {6'd0, sel_a}, 8'h00);
        adv();
        nop(); #1;
        chk("lu_sel_a", {6'd0, sel_a}, 8'h02);
        chk("lu_sel_b", {6'd0, sel_b}, 8'h00);
        chk("lu_stall_c2", {7'd0, stall}, 8'd0);
        drain();

        // 4b: matching rs but not read -> no stall
        id_set(1, 5'd1, 5'd0, 1, 0, 5'd2, 1, 1); adv();
        id_set(1, 5'd2, 5'd2, 0, 0, 5'd6, 1, 0); #1;
        chk("lu_unused_stall", {7'd0, stall}, 8'd0);
        drain();

        // 4c: back-to-back load-use pairs, rt dependency on the second
        id_set(1, 5'd1, 5'd0, 1, 0, 5'd2, 1, 1); adv();
        id_set(1, 5'd2, 5'd0, 1, 0, 5'd8, 1, 1); #1;      // lw r8,(r2)
        chk("b2b_stall0", {7'd0, stall}, 8'd1);
        adv(); adv();                                     // lw r8 now in EX
        chk("b2b_sel_a0", {6'd0, sel_a}, 8'h02);
        id_set(1, 5'd9, 5'd8, 1, 1, 5'd10, 1, 0); #1;
        chk("b2b_stall1", {7'd0, stall}, 8'd1);
        adv();
        chk("b2b_stall1_end", {7'd0, stall}, 8'd0);
        adv();
        nop(); #1;
        chk("b2b_sel_b1", {6'd0, sel_b}, 8'h02);
        drain();

        // 5a: r0 never forwards nor stalls
        id_set(1, 5'd1, 5'd2, 1, 1, 5'd0, 1, 0); adv();   // add r0
        id_set(1, 5'd0, 5'd0, 1, 1, 5'd5, 1, 0); #1;
        chk("r0_stall", {7'd0, stall}, 8'd0);
        adv();
        nop(); #1;
        chk("r0_sel_a", {6'd0, sel_a}, 8'h00);
        chk("r0_sel_b", {6'd0, sel_b}, 8'h00);
        drain();
        id_set(1, 5'd1, 5'd0, 1, 0, 5'd0, 1, 1); adv();   // lw r0
        id_set(1, 5'd0, 5'd0, 1, 1, 5'd5, 1, 0); #1;
        chk("r0_lw_stall", {7'd0, stall}, 8'd0);
        drain();

        // 5b: flush beats stall
        id_set(1, 5'd1, 5'd0, 1, 0, 5'd2, 1, 1); adv();
        id_set(1, 5'd2, 5'd7, 1, 1, 5'd6, 1, 0); branch_taken = 1'b1; #1;
        chk("fl_flush", {7'd0, flush}, 8'd1);
        chk("fl_stall", {7'd0, stall}, 8'd0);
        adv();
        branch_taken = 1'b0; nop(); #1;
        chk("fl_flush_off", {7'd0, flush}, 8'd0);
        chk("fl_ex_bubble_a", {6'd0, sel_a}, 8'h00);
        chk("fl_ex_bubble_b", {6'd0, sel_b}, 8'h00);
        drain();

        // 6: async reset mid-stall
        id_set(1, 5'd1, 5'd0, 1, 0, 5'd2, 1, 1); adv();
        id_set(1, 5'd2, 5'd7, 1, 1, 5'd6, 1, 0); #1;
        chk("ar_stall_pre", {7'd0, stall}, 8'd1);
        #1 rst_n = 1'b0; #1;
        chk("ar_stall_async", {7'd0, stall}, 8'd0);
        branch_taken = 1'b1; #1;
        chk("ar_flush_async", {7'd0, flush}, 8'd0);
        branch_taken = 1'b0;
        adv();
        rst_n = 1'b1; #1;
        chk("ar_stall_rel", {7'd0, stall}, 8'd0);
        adv();                                            // add enters EX, no producers
        nop(); #1;
        chk("ar_sel_a", {6'd0, sel_a}, 8'h00);
        chk("ar_sel_b", {6'd0, sel_b}, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
